// File: rtl/dcache_dm_if.sv
// dcache_dm_if
// Bundles the two handshake buses of the direct-mapped data cache:
//   pipeline side : req, uop, addr, data_in  -> ready, done, data_out, hit
//   memory side   : mem_req, mem_we, mem_addr, mem_wdata -> mem_ack, mem_rdata
// Modports:
//   master : the environment (pipeline + backing memory) driving the cache
//   slave  : the cache itself
interface dcache_dm_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req;
  logic [4:0]            uop;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  ready;
  logic                  done;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  hit;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output req, uop, addr, data_in, mem_ack, mem_rdata,
    input  ready, done, data_out, hit, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req, uop, addr, data_in, mem_ack, mem_rdata,
    output ready, done, data_out, hit, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_dm.sv
// dcache_dm
// Direct-mapped, write-through, one-word-per-line data cache sitting between
// the LDR/STR path of the pipeline and a slow backing memory. One request is
// outstanding at a time; load misses refill the line, stores write through
// and only update the line when it already hits (no write-allocate).
// Ports:
//   clock, reset        : single clock, synchronous active-high reset
//   bus (slave)         : pipeline request/completion and memory req/ack
//   hit_count           : saturating count of load hits
//   miss_count          : saturating count of load misses
module dcache_dm #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int LINES       = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  dcache_dm_if.slave             bus,
  output logic [COUNT_WIDTH-1:0] hit_count,
  output logic [COUNT_WIDTH-1:0] miss_count
);

  localparam logic [4:0] STR_UOP = 5'b01001;
  localparam logic [4:0] LDR_UOP = 5'b01010;
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_WIDTH - IDX_W;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;

  state_t state;

  logic [DATA_WIDTH-1:0] line_data  [LINES];
  logic [TAG_W-1:0]      line_tag   [LINES];
  logic [LINES-1:0]      line_valid;

  logic                  done_q;
  logic                  hit_q;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  mem_req_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;

  // The memory address register doubles as the latched request address, so
  // the pending line index/tag are taken from it during RD_MISS/WR_THRU.
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] lat_idx;
  logic [TAG_W-1:0] lat_tag;
  logic             req_hit;
  logic             lat_hit;

  assign req_idx = bus.addr[IDX_W-1:0];
  assign req_tag = bus.addr[ADDR_WIDTH-1:IDX_W];
  assign lat_idx = mem_addr_q[IDX_W-1:0];
  assign lat_tag = mem_addr_q[ADDR_WIDTH-1:IDX_W];
  assign req_hit = line_valid[req_idx] && (line_tag[req_idx] == req_tag);
  assign lat_hit = line_valid[lat_idx] && (line_tag[lat_idx] == lat_tag);

  assign bus.ready     = (state == IDLE) && !reset;
  assign bus.done      = done_q;
  assign bus.hit       = hit_q;
  assign bus.data_out  = data_out_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  // Single controller: every output is registered, done/hit/data_out default
  // to zero each cycle so they form one-cycle completion pulses. Line data and
  // tags are not reset; clearing the valid bits is enough to invalidate them.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      line_valid  <= '0;
      done_q      <= 1'b0;
      hit_q       <= 1'b0;
      data_out_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hit_count   <= '0;
      miss_count  <= '0;
    end else begin
      done_q     <= 1'b0;
      hit_q      <= 1'b0;
      data_out_q <= '0;
      case (state)
        IDLE: begin
          if (bus.req) begin
            if (bus.uop == LDR_UOP) begin
              if (req_hit) begin
                done_q     <= 1'b1;
                hit_q      <= 1'b1;
                data_out_q <= line_data[req_idx];
                if (hit_count != '1) hit_count <= hit_count + 1'b1;
              end else begin
                state      <= RD_MISS;
                mem_req_q  <= 1'b1;
                mem_we_q   <= 1'b0;
                mem_addr_q <= bus.addr;
                if (miss_count != '1) miss_count <= miss_count + 1'b1;
              end
            end else if (bus.uop == STR_UOP) begin
              state       <= WR_THRU;
              mem_req_q   <= 1'b1;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= bus.addr;
              mem_wdata_q <= bus.data_in;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        RD_MISS: begin
          if (bus.mem_ack) begin
            line_data[lat_idx]  <= bus.mem_rdata;
            line_tag[lat_idx]   <= lat_tag;
            line_valid[lat_idx] <= 1'b1;
            data_out_q          <= bus.mem_rdata;
            done_q              <= 1'b1;
            mem_req_q           <= 1'b0;
            state               <= IDLE;
          end
        end
        WR_THRU: begin
          if (bus.mem_ack) begin
            // No write-allocate: a missing line keeps its old valid/tag.
            if (lat_hit) line_data[lat_idx] <= mem_wdata_q;
            done_q    <= 1'b1;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_dm.sv
// tb_dcache_dm
// Directed bench for dcache_dm. A second instance with 2-bit counters sees
// the exact same stimulus and is used only to observe counter saturation.
module tb_dcache_dm;

  localparam logic [4:0] STR_UOP = 5'b01001;
  localparam logic [4:0] LDR_UOP = 5'b01010;

  logic        clock;
  logic        reset;
  logic [15:0] hit_count;
  logic [15:0] miss_count;
  logic [1:0]  sat_hit_count;
  logic [1:0]  sat_miss_count;

  int tests;
  int fails;

  dcache_dm_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();
  dcache_dm_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) sat_bus ();

  dcache_dm #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .LINES(32), .COUNT_WIDTH(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .hit_count(hit_count),
    .miss_count(miss_count)
  );

  dcache_dm #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .LINES(32), .COUNT_WIDTH(2)
  ) dut_sat (
    .clock(clock),
    .reset(reset),
    .bus(sat_bus),
    .hit_count(sat_hit_count),
    .miss_count(sat_miss_count)
  );

  // The saturation instance mirrors every input of the main instance.
  assign sat_bus.req       = bus.req;
  assign sat_bus.uop       = bus.uop;
  assign sat_bus.addr      = bus.addr;
  assign sat_bus.data_in   = bus.data_in;
  assign sat_bus.mem_ack   = bus.mem_ack;
  assign sat_bus.mem_rdata = bus.mem_rdata;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to just after the next rising edge, where outputs are settled.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, observed, expected);
    end
  endtask

  // Present one request for exactly one acceptance edge.
  task automatic applyStimulus(input logic [4:0] u, input logic [31:0] a,
                               input logic [31:0] d);
    bus.req     = 1'b1;
    bus.uop     = u;
    bus.addr    = a;
    bus.data_in = d;
    checkOutput("ready_before_accept", bus.ready, 1'b1);
    tick();
    bus.req = 1'b0;
  endtask

  // Backing memory: hold off mem_ack for 'delay' cycles while checking that
  // the request stays stable, then ack with rdata for one cycle.
  task automatic serveMem(input int delay, input logic [31:0] rdata,
                          input logic exp_we, input logic [31:0] exp_addr,
                          input logic [31:0] exp_wdata);
    for (int i = 0; i <= delay; i++) begin
      checkOutput("mem_req_held", bus.mem_req, 1'b1);
      checkOutput("mem_we", bus.mem_we, exp_we);
      checkOutput("mem_addr", bus.mem_addr, exp_addr);
      if (exp_we) checkOutput("mem_wdata", bus.mem_wdata, exp_wdata);
      checkOutput("ready_low_busy", bus.ready, 1'b0);
      if (i == delay) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rdata;
      end
      tick();
    end
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    reset         = 1'b1;
    bus.req       = 1'b0;
    bus.uop       = 5'b0;
    bus.addr      = 32'h0;
    bus.data_in   = 32'h0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;

    // Reset state
    tick();
    tick();
    checkOutput("rst_ready", bus.ready, 1'b0);
    checkOutput("rst_done", bus.done, 1'b0);
    checkOutput("rst_hit", bus.hit, 1'b0);
    checkOutput("rst_data_out", bus.data_out, 32'h0);
    checkOutput("rst_mem_req", bus.mem_req, 1'b0);
    checkOutput("rst_mem_we", bus.mem_we, 1'b0);
    checkOutput("rst_mem_addr", bus.mem_addr, 32'h0);
    checkOutput("rst_mem_wdata", bus.mem_wdata, 32'h0);
    checkOutput("rst_hit_count", hit_count, 16'd0);
    checkOutput("rst_miss_count", miss_count, 16'd0);
    reset = 1'b0;
    #1;
    checkOutput("ready_after_rst", bus.ready, 1'b1);

    // Cold load miss with a 3-cycle memory delay
    applyStimulus(LDR_UOP, 32'h5, 32'h0);
    checkOutput("miss_count_at_accept", miss_count, 16'd1);
    serveMem(3, 32'hDEADBEEF, 1'b0, 32'h5, 32'h0);
    checkOutput("ldmiss_done", bus.done, 1'b1);
    checkOutput("ldmiss_hit", bus.hit, 1'b0);
    checkOutput("ldmiss_data", bus.data_out, 32'hDEADBEEF);
    checkOutput("ldmiss_mem_req_drop", bus.mem_req, 1'b0);
    tick();
    checkOutput("done_clears", bus.done, 1'b0);
    checkOutput("data_out_clears", bus.data_out, 32'h0);

    // Two back-to-back load hits
    bus.req  = 1'b1;
    bus.uop  = LDR_UOP;
    bus.addr = 32'h5;
    tick();
    checkOutput("hit1_done", bus.done, 1'b1);
    checkOutput("hit1_hit", bus.hit, 1'b1);
    checkOutput("hit1_data", bus.data_out, 32'hDEADBEEF);
    checkOutput("hit1_ready", bus.ready, 1'b1);
    checkOutput("hit1_mem_req", bus.mem_req, 1'b0);
    tick();
    bus.req = 1'b0;
    checkOutput("hit2_done", bus.done, 1'b1);
    checkOutput("hit2_hit", bus.hit, 1'b1);
    checkOutput("hit2_data", bus.data_out, 32'hDEADBEEF);
    checkOutput("hit2_mem_req", bus.mem_req, 1'b0);
    checkOutput("hit_count_2", hit_count, 16'd2);
    checkOutput("sat_hit_count_2", sat_hit_count, 2'd2);
    tick();
    checkOutput("hit_done_clears", bus.done, 1'b0);

    // Store to cached line, then load it back
    applyStimulus(STR_UOP, 32'h5, 32'h12345678);
    serveMem(1, 32'h0, 1'b1, 32'h5, 32'h12345678);
    checkOutput("str_done", bus.done, 1'b1);
    checkOutput("str_hit", bus.hit, 1'b0);
    checkOutput("str_data_out", bus.data_out, 32'h0);
    checkOutput("str_mem_we_drop", bus.mem_we, 1'b0);
    checkOutput("str_no_count", hit_count, 16'd2);
    applyStimulus(LDR_UOP, 32'h5, 32'h0);
    checkOutput("ld_after_str_hit", bus.hit, 1'b1);
    checkOutput("ld_after_str_data", bus.data_out, 32'h12345678);
    checkOutput("sat_hit_count_3", sat_hit_count, 2'd3);

    // Fourth hit: the 2-bit counter must stay saturated
    applyStimulus(LDR_UOP, 32'h5, 32'h0);
    checkOutput("hit4_hit", bus.hit, 1'b1);
    checkOutput("hit_count_4", hit_count, 16'd4);
    checkOutput("sat_hit_count_stuck", sat_hit_count, 2'd3);

    // Aliasing: 0x25 shares index 5 with 0x5
    applyStimulus(LDR_UOP, 32'h25, 32'h0);
    checkOutput("alias_miss_req", bus.mem_req, 1'b1);
    serveMem(0, 32'hCAFEF00D, 1'b0, 32'h25, 32'h0);
    checkOutput("alias_done", bus.done, 1'b1);
    checkOutput("alias_hit", bus.hit, 1'b0);
    checkOutput("alias_data", bus.data_out, 32'hCAFEF00D);
    checkOutput("miss_count_2", miss_count, 16'd2);
    tick();
    applyStimulus(LDR_UOP, 32'h5, 32'h0);
    checkOutput("evicted_miss_req", bus.mem_req, 1'b1);
    checkOutput("evicted_no_done", bus.done, 1'b0);
    serveMem(0, 32'h12345678, 1'b0, 32'h5, 32'h0);
    checkOutput("evicted_data", bus.data_out, 32'h12345678);
    checkOutput("miss_count_3", miss_count, 16'd3);

    // Store to an uncached address does not allocate
    applyStimulus(STR_UOP, 32'h40, 32'h0000A5A5);
    serveMem(0, 32'h0, 1'b1, 32'h40, 32'h0000A5A5);
    checkOutput("str_uncached_done", bus.done, 1'b1);
    applyStimulus(LDR_UOP, 32'h40, 32'h0);
    checkOutput("no_alloc_miss_req", bus.mem_req, 1'b1);
    checkOutput("no_alloc_hit", bus.hit, 1'b0);
    serveMem(0, 32'h0000A5A5, 1'b0, 32'h40, 32'h0);
    checkOutput("no_alloc_data", bus.data_out, 32'h0000A5A5);
    checkOutput("miss_count_4", miss_count, 16'd4);
    checkOutput("sat_miss_count_stuck", sat_miss_count, 2'd3);

    // Reset during a pending refill, with a late ack afterwards
    applyStimulus(LDR_UOP, 32'h7, 32'h0);
    checkOutput("pend_mem_req", bus.mem_req, 1'b1);
    tick();
    reset = 1'b1;
    #1;
    checkOutput("ready_low_in_reset", bus.ready, 1'b0);
    tick();
    reset = 1'b0;
    checkOutput("abort_mem_req", bus.mem_req, 1'b0);
    checkOutput("abort_done", bus.done, 1'b0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hBAD0BAD0;
    tick();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    checkOutput("late_ack_done", bus.done, 1'b0);
    checkOutput("late_ack_data", bus.data_out, 32'h0);
    checkOutput("late_ack_mem_req", bus.mem_req, 1'b0);
    checkOutput("post_rst_hit_count", hit_count, 16'd0);
    checkOutput("post_rst_miss_count", miss_count, 16'd0);
    applyStimulus(LDR_UOP, 32'h5, 32'h0);
    checkOutput("post_rst_miss_req", bus.mem_req, 1'b1);
    checkOutput("post_rst_miss_count_1", miss_count, 16'd1);
    serveMem(0, 32'h12345678, 1'b0, 32'h5, 32'h0);
    checkOutput("post_rst_done", bus.done, 1'b1);
    checkOutput("post_rst_hit", bus.hit, 1'b0);
    checkOutput("post_rst_hit_count_0", hit_count, 16'd0);

    // Unknown uop completes with no memory traffic
    applyStimulus(5'b00000, 32'h5, 32'hFFFFFFFF);
    checkOutput("nop_done", bus.done, 1'b1);
    checkOutput("nop_hit", bus.hit, 1'b0);
    checkOutput("nop_data", bus.data_out, 32'h0);
    checkOutput("nop_mem_req", bus.mem_req, 1'b0);
    checkOutput("nop_no_count", hit_count, 16'd0);
    tick();
    checkOutput("nop_done_clears", bus.done, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dcache_dm.md
# dcache_dm

Parametrised direct-mapped, write-through data cache for the CPU's LDR/STR path, fronting a slow backing data memory through a req/ack handshake. It replaces the fixed 32-word, always-ready data store with tagged lines, valid bits and miss handling. A single-outstanding-request protocol toward the pipeline lets the execute stage stall on misses. Saturating hit/miss counters provide performance visibility.

## Interface
- STR_UOP, 5'b01001, uop code for word store
- LDR_UOP, 5'b01010, uop code for word load
- DATA_WIDTH, 32, word width
- ADDR_WIDTH, 32, word-address width
- LINES, 32, number of one-word lines; power of two, >= 2; IDX_W = log2(LINES), TAG_W = ADDR_WIDTH - IDX_W
- COUNT_WIDTH, 16, width of each performance counter
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  1  request valid from pipeline
- uop  in  5  operation code
- addr  in  ADDR_WIDTH  word address; index = addr[IDX_W-1:0], tag = addr[ADDR_WIDTH-1:IDX_W]
- data_in  in  DATA_WIDTH  store data
- ready  out  1  cache accepts a request this cycle
- done  out  1  one-cycle completion pulse
- data_out  out  DATA_WIDTH  load result, valid while done=1
- hit  out  1  qualified by done: 1 = load hit
- mem_req, mem_we  out  1 each  backing-memory request / write enable
- mem_addr  out  ADDR_WIDTH;  mem_wdata  out  DATA_WIDTH
- mem_ack  in  1;  mem_rdata  in  DATA_WIDTH
- hit_count, miss_count  out  COUNT_WIDTH each  saturating load hit/miss counters

## Operation
- States: IDLE, RD_MISS, WR_THRU. ready = (state==IDLE) & ~reset.
- Acceptance occurs when req & ready at a rising edge. The block latches uop/addr/data_in.
- LDR, hit (valid[idx] & tag match):
  - stays IDLE;
  - next cycle: done=1, hit=1, data_out=line data;
  - hit_count++.
- LDR, miss:
  - goes to RD_MISS;
  - miss_count++ at acceptance.
- RD_MISS:
  - mem_req=1, mem_we=0, mem_addr=latched addr;
  - on edge with mem_ack=1: line[idx] <= mem_rdata, tag written, valid[idx] <= 1, data_out <= mem_rdata, go IDLE;
  - next cycle: done=1, hit=0.
- STR:
  - goes to WR_THRU: mem_req=1, mem_we=1, mem_addr/mem_wdata = latched values;
  - on edge with mem_ack=1: if the line hits, its data is updated; if it misses, it is not allocated and valid/tag are unchanged. Go IDLE;
  - next cycle: done=1, hit=0, data_out=0.
- Any other uop with req: accepted, no state or memory change, next cycle done=1, hit=0, data_out=0.
- Counters saturate at all-ones and do not wrap. STR and other uops do not count.
- mem_req, mem_we, mem_addr and mem_wdata hold stable from assertion until the ack edge. mem_ack is ignored in IDLE.

## Timing
- Reset (synchronous, checked before all else): state=IDLE, all valid bits=0, done=0, hit=0, data_out=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, counters=0. ready=0 while reset is high.
- Reset mid-miss or mid-write:
  - the transaction is abandoned with no done and no line update;
  - mem_req drops in the cycle after the reset edge;
  - a late mem_ack is ignored.
- Load hit latency: 1 cycle (accept at edge N, done during cycle N+1). Throughput is 1 hit per cycle, since ready stays high while done is asserted.
- Miss/store latency: (cycles until mem_ack) + 1. With mem_ack tied high, a load miss takes 2 cycles and a store takes 2 cycles.
- done and data_out are registered. data_out returns to 0 the cycle after done unless a new completion occurs.
- A store immediately followed by a load to the same address returns the stored value. Ordering is guaranteed because the load is only accepted after the store's done.
- Aliasing: two addresses with equal index and different tag evict each other.

## Test plan
- Reset, then LDR addr=0x5 with mem_ack delay 3, mem_rdata=0xDEADBEEF:
  - mem_req held with mem_addr=0x5, mem_we=0 for 4 cycles;
  - done with data_out=0xDEADBEEF, hit=0, miss_count=1.
- Repeat LDR 0x5 twice back-to-back: done on consecutive cycles, hit=1, data_out=0xDEADBEEF, mem_req stays 0, hit_count=2.
- STR 0x5 data 0x12345678, then LDR 0x5:
  - mem_we=1, mem_wdata=0x12345678;
  - the load hits and returns 0x12345678.
- Alias, LINES=32: load 0x25 after 0x5 misses and refills; a following LDR 0x5 misses again. STR to uncached 0x40 leaves 0x40 a miss on the next LDR.
- Reset asserted during RD_MISS before ack, ack arrives afterwards:
  - no done;
  - mem_req=0 the cycle after the reset edge;
  - LDR 0x5 then misses (valid cleared), counters restart at 0.
- Uop 5'b00000 with req: done next cycle, data_out=0, no mem_req. Force hit_count to all-ones via COUNT_WIDTH=2 and 4 hits: the counter stays at 3.
